lock_access_ctrl: RTL
=====================

// Module: lock_access_ctrl
// PURPOSE
//  Access controller for the electronic lock. Gates user key strobes into the sequence detector and frames
//  each CODE_LEN-press attempt. Samples the detector hit after each attempt, drives the door-unlock hold
//  timer, and counts failed attempts into a timed lockout. Sits between the keypad front end and the detector.
// PARAMETERS
//  CODE_LEN   5      presses per attempt
//  MAX_FAIL   3      consecutive failed attempts that trigger lockout (>=1)
//  OPEN_CYC   1000   cycles unlock is held high after a good attempt
//  LOCK_CYC   10000  cycles of lockout
//  ENTRY_TO   500    max idle cycles between presses within an attempt
//  HIT_LAT    1      cycles from last det_vld to a valid det_hit
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  key_b0     in   1  one-cycle press strobe, key "0"
//  key_b1     in   1  one-cycle press strobe, key "1"
//  det_vld    out  1  one-cycle strobe: detector steps on det_bit
//  det_bit    out  1  pressed digit (1 = key_b1)
//  det_clr    out  1  one-cycle detector clear to start state
//  det_hit    in   1  detector match flag, valid HIT_LAT cycles after final det_vld
//  unlock     out  1  door release
//  locked_out out  1  keypad disabled
//  fail_cnt   out  $clog2(MAX_FAIL+1)  consecutive failed attempts
//  busy       out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; all outputs and counters 0.
//  Press = exactly one of key_b0/key_b1 high. Both high in the same cycle is ignored (no det_vld, no count).
//  det_vld/det_bit are registered: 1-cycle latency from the press. Presses are never forwarded outside IDLE/ENTRY.
//  FSM:
//   IDLE:    press -> forward, press_cnt=1, go to ENTRY.
//   ENTRY:   press -> forward, press_cnt++. On press_cnt==CODE_LEN -> CHECK.
//            ENTRY_TO cycles with no press -> FAIL (timeout counts as a failure).
//   CHECK:   wait HIT_LAT cycles after final det_vld, sample det_hit once.
//            Hit -> OPEN, fail_cnt=0. Miss -> FAIL.
//   OPEN:    unlock=1 for exactly OPEN_CYC cycles. Presses ignored. Then -> IDLE with det_clr pulse.
//   FAIL:    single cycle. fail_cnt++ (saturates at MAX_FAIL), det_clr pulse.
//            fail_cnt reaches MAX_FAIL -> LOCKOUT, else -> IDLE.
//   LOCKOUT: locked_out=1 for LOCK_CYC cycles. Presses ignored.
//            On expiry: fail_cnt=0, det_clr pulse, -> IDLE.
//  det_clr is also pulsed on the first cycle after reset release.
//  Timers are down-counters sized $clog2(max+1). Loaded on state entry, expire when count reaches 0.
//  No wrap-around: counts stop at 0.
//  A press on the cycle a timer expires is dropped.
//  Reset mid-attempt or mid-OPEN: unlock drops immediately (asynchronously), and the attempt is discarded.
// CONFIGURATION
//  LOCK_ALARM_EN defined: adds output `alarm` (1 bit). alarm=1 during the first min(LOCK_CYC,256) cycles
//  of LOCKOUT, otherwise 0. Reset value 0.
//  Not defined: no alarm port, and no alarm logic.
// STRUCTURE
//  Package lock_pkg: state enum lock_state_t {IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT}, plus the default
//  timing constants. The detector's digit encoding constant DIGIT_ONE=1'b1 also lives there.
//  One sub-module: lock_dn_timer (loadable down-counter with a zero flag). It is instantiated once and
//  shared by the ENTRY/OPEN/LOCKOUT timing, since only one of those runs at a time.
// TESTING (CODE_LEN=5, MAX_FAIL=3, OPEN_CYC=8, LOCK_CYC=20, ENTRY_TO=6, HIT_LAT=1)
//  1. Good code: press 0,1,0,1,1 one cycle apart, detector model asserts det_hit
//     -> unlock high exactly 8 cycles, fail_cnt=0, det_clr pulse, then IDLE.
//  2. Three wrong 5-press attempts -> fail_cnt 1,2,3, then locked_out high 20 cycles.
//     Presses during lockout produce no det_vld. Afterwards fail_cnt=0.
//  3. Two presses, then 6 idle cycles -> FAIL, fail_cnt=1, det_clr pulse, no unlock.
//  4. key_b0 and key_b1 high in the same cycle mid-attempt -> no det_vld, press_cnt unchanged,
//     and the attempt still needs 5 valid presses.
//  5. Assert reset in the 3rd cycle of OPEN -> unlock=0 in the same cycle, busy=0, fail_cnt=0.
//     After release, det_clr pulses once.
//  6. With LOCK_ALARM_EN, rerun scenario 2 -> alarm high for 20 cycles, aligned with locked_out.
//     Without the macro, the build has no alarm port.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and default timing for the electronic-lock access controller.
package lock_pkg;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT} lock_state_t;

  localparam int CODE_LEN_D = 5;
  localparam int MAX_FAIL_D = 3;
  localparam int OPEN_CYC_D = 1000;
  localparam int LOCK_CYC_D = 10000;
  localparam int ENTRY_TO_D = 500;
  localparam int HIT_LAT_D  = 1;
  localparam int ALARM_CYC  = 256;

  localparam logic DIGIT_ONE = 1'b1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_dn_timer.sv
// Loadable down-counter that stops at zero; zero flag marks expiry.
module lock_dn_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lock_access_ctrl.sv
// Lock access controller: frames key attempts, checks detector hit, drives unlock and lockout.
// Optional LOCK_ALARM_EN adds the alarm output during the first cycles of lockout.
module lock_access_ctrl
  import lock_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_D,
  parameter int MAX_FAIL = MAX_FAIL_D,
  parameter int OPEN_CYC = OPEN_CYC_D,
  parameter int LOCK_CYC = LOCK_CYC_D,
  parameter int ENTRY_TO = ENTRY_TO_D,
  parameter int HIT_LAT  = HIT_LAT_D
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_b0,
  input  logic                          key_b1,
  output logic                          det_vld,
  output logic                          det_bit,
  output logic                          det_clr,
  input  logic                          det_hit,
  output logic                          unlock,
  output logic                          locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          busy
`ifdef LOCK_ALARM_EN
  ,output logic                         alarm
`endif
);

  localparam int TMAX = imax(imax(OPEN_CYC, LOCK_CYC), imax(ENTRY_TO, HIT_LAT));
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int PW   = $clog2(CODE_LEN + 1);

  lock_state_t   state, next_state;
  logic [PW-1:0] press_cnt;
  logic          rst_seen;
  logic          press, press_ok;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val, tmr_cnt;

  // Both keys at once is not a press; the expiry cycle of the entry timer drops presses.
  assign press    = key_b0 ^ key_b1;
  assign press_ok = press && ((state == IDLE) || (state == ENTRY && !tmr_zero));

  lock_dn_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (press_ok) next_state = (CODE_LEN == 1) ? CHECK : ENTRY;
      ENTRY:   if (tmr_zero) next_state = FAIL;
               else if (press_ok && press_cnt == PW'(CODE_LEN - 1)) next_state = CHECK;
      CHECK:   if (tmr_zero) next_state = det_hit ? OPEN : FAIL;
      OPEN:    if (tmr_zero) next_state = IDLE;
      FAIL:    next_state = (fail_cnt >= FW'(MAX_FAIL - 1)) ? LOCKOUT : IDLE;
      LOCKOUT: if (tmr_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Hold-type timers load N-1 so the state lasts exactly N cycles; CHECK loads the raw latency.
  always_comb begin
    tmr_load = (next_state != state) || (state == ENTRY && press_ok);
    tmr_val  = '0;
    case (next_state)
      ENTRY:   tmr_val = TW'(ENTRY_TO - 1);
      CHECK:   tmr_val = TW'(HIT_LAT);
      OPEN:    tmr_val = TW'(OPEN_CYC - 1);
      LOCKOUT: tmr_val = TW'(LOCK_CYC - 1);
      default: tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_cnt <= '0;
      fail_cnt  <= '0;
      det_vld   <= 1'b0;
      det_bit   <= 1'b0;
      det_clr   <= 1'b0;
      rst_seen  <= 1'b0;
    end else begin
      rst_seen <= 1'b1;
      det_vld  <= press_ok;
      det_bit  <= press_ok ? (key_b1 ? DIGIT_ONE : ~DIGIT_ONE) : 1'b0;
      det_clr  <= !rst_seen
               || (next_state == FAIL && state != FAIL)
               || ((state == OPEN || state == LOCKOUT) && next_state == IDLE);

      if (press_ok)            press_cnt <= (state == IDLE) ? PW'(1) : press_cnt + 1'b1;
      else if (state != ENTRY) press_cnt <= '0;

      if (state == FAIL)
        fail_cnt <= (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
      else if ((state == CHECK && tmr_zero && det_hit) || (state == LOCKOUT && tmr_zero))
        fail_cnt <= '0;
    end
  end

  // Decoded straight from the state register so reset drops unlock immediately.
  always_comb begin
    unlock     = (state == OPEN);
    locked_out = (state == LOCKOUT);
    busy       = (state != IDLE);
  end

`ifdef LOCK_ALARM_EN
  localparam int            ALARM_TH_I = (LOCK_CYC > ALARM_CYC) ? LOCK_CYC - ALARM_CYC : 0;
  localparam logic [TW-1:0] ALARM_TH   = TW'(ALARM_TH_I);
  always_comb alarm = (state == LOCKOUT) && (tmr_cnt >= ALARM_TH);
`else
  logic unused_tmr_cnt;
  assign unused_tmr_cnt = ^tmr_cnt;
`endif

endmodule
